spm_program_loader: RTL and testbench

SPM_PROGRAM_LOADER -- requirements
Module: spm_program_loader

---
 rtl/spm_pkg.sv | 17 +
 rtl/spm_program_loader.sv | 137 +++++++++++++
 tb/tb_spm_program_loader.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/spm_pkg.sv
// Shared definitions for the scratch-pad program loader, the CPU it feeds,
// and the bench: loader state encoding and default memory geometry.
package spm_pkg;

  localparam int unsigned SPM_WORD_SIZE = 8;
  localparam int unsigned SPM_ADDR_SIZE = 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CLEAR   = 3'd1,
    LOAD    = 3'd2,
    RUN     = 3'd3,
    HALTED  = 3'd4,
    TIMEOUT = 3'd5
  } spm_state_e;

endpackage

// File: rtl/spm_program_loader.sv
// Program loader for a scratch-pad CPU memory.
// A session (start) optionally zero-fills the whole memory, streams a program
// image in from a valid/ready source starting at base_addr (address wraps),
// then releases the CPU from reset and times its run until HALT or timeout.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   start                one-cycle session request (IDLE/HALTED/TIMEOUT only)
//   clear_en, base_addr  session options, sampled with start
//   in_valid/in_ready    program word handshake; in_data word, in_last final
//   mem_wr/mem_addr/     memory write port
//   mem_wdata
//   cpu_rst              CPU hold-in-reset (low only while running)
//   cpu_halt             CPU has executed HALT
//   busy, done, timeout  session status
//   run_cycles           CPU cycles spent in RUN (saturating)
module spm_program_loader
  import spm_pkg::*;
#(
  parameter int unsigned WORD_SIZE   = SPM_WORD_SIZE,
  parameter int unsigned ADDR_SIZE   = SPM_ADDR_SIZE,
  parameter int unsigned TIMEOUT_CYC = 1400
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 clear_en,
  input  logic [ADDR_SIZE-1:0] base_addr,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WORD_SIZE-1:0] in_data,
  input  logic                 in_last,
  output logic                 mem_wr,
  output logic [ADDR_SIZE-1:0] mem_addr,
  output logic [WORD_SIZE-1:0] mem_wdata,
  output logic                 cpu_rst,
  input  logic                 cpu_halt,
  output logic                 busy,
  output logic                 done,
  output logic                 timeout,
  output logic [15:0]          run_cycles
);

  localparam logic [31:0] RUN_LAST = 32'(TIMEOUT_CYC - 1);

  spm_state_e           state_q, state_d;
  logic [ADDR_SIZE-1:0] base_q, base_d;
  // Shared offset: clear address in CLEAR, load offset in LOAD.
  logic [ADDR_SIZE-1:0] off_q, off_d;
  logic [15:0]          run_q, run_d;
  logic                 cpu_rst_q, cpu_rst_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 timeout_q, timeout_d;

  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    off_d     = off_q;
    run_d     = run_q;
    in_ready  = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;

    unique case (state_q)
      IDLE, HALTED, TIMEOUT: begin
        if (start) begin
          base_d  = base_addr;
          off_d   = '0;
          run_d   = '0;
          state_d = clear_en ? CLEAR : LOAD;
        end
      end
      CLEAR: begin
        mem_wr   = 1'b1;
        mem_addr = off_q;
        // Offset rolls over to 0 on the last address, ready for LOAD.
        off_d    = off_q + 1'b1;
        if (off_q == '1) state_d = LOAD;
      end
      LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          mem_wr    = 1'b1;
          mem_addr  = base_q + off_q;
          mem_wdata = in_data;
          off_d     = off_q + 1'b1;
          if (in_last) state_d = RUN;
        end
      end
      RUN: begin
        // The exiting cycle is counted too, so halting in the Nth RUN
        // cycle reports N.
        run_d = (run_q == 16'hFFFF) ? run_q : run_q + 16'd1;
        if (cpu_halt)                     state_d = HALTED;
        else if ({16'h0, run_q} == RUN_LAST) state_d = TIMEOUT;
      end
      default: state_d = IDLE;
    endcase

    // Status flags are registered from the next state so they line up with it.
    cpu_rst_d = (state_d != RUN);
    busy_d    = (state_d == CLEAR) || (state_d == LOAD) || (state_d == RUN);
    done_d    = (state_d == HALTED) || (state_d == TIMEOUT);
    timeout_d = (state_d == TIMEOUT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      base_q    <= '0;
      off_q     <= '0;
      run_q     <= '0;
      cpu_rst_q <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      off_q     <= off_d;
      run_q     <= run_d;
      cpu_rst_q <= cpu_rst_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
    end
  end

  assign cpu_rst    = cpu_rst_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign timeout    = timeout_q;
  assign run_cycles = run_q;

endmodule

// File: tb/tb_spm_program_loader.sv
`timescale 1ns/1ps
module tb_spm_program_loader;
  import spm_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        clear_en = 1'b0;
  logic [7:0]  base_addr = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_data = '0;
  logic        in_last = 1'b0;
  logic        mem_wr;
  logic [7:0]  mem_addr;
  logic [7:0]  mem_wdata;
  logic        cpu_rst;
  logic        cpu_halt = 1'b0;
  logic        busy, done, timeout;
  logic [15:0] run_cycles;

  spm_program_loader #(
    .WORD_SIZE  (8),
    .ADDR_SIZE  (8),
    .TIMEOUT_CYC(100)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .clear_en  (clear_en),
    .base_addr (base_addr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .mem_wr    (mem_wr),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_rst   (cpu_rst),
    .cpu_halt  (cpu_halt),
    .busy      (busy),
    .done      (done),
    .timeout   (timeout),
    .run_cycles(run_cycles)
  );

  always #5 clk = ~clk;

  // Write monitor: memory image and ordered write log.
  logic [7:0]  mem_model [256];
  logic [15:0] wlog [$];
  always @(negedge clk) begin
    if (mem_wr) begin
      wlog.push_back({mem_addr, mem_wdata});
      mem_model[mem_addr] = mem_wdata;
    end
  end

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] dat(input int v, input int i);
    return 8'(8'h80 | ((v * 16 + i * 7) & 8'h7f));
  endfunction

  typedef struct {
    logic       clr;
    logic [7:0] base;
    int         nwords;
    logic       gap;
    int         halt_cyc;      // 0 = never halt
    int         start_in_run;  // 0 = no stray start
    logic       exp_done;
    logic       exp_to;
    int         exp_run;
    logic [7:0] exp_last;
  } vec_t;

  vec_t vecs [6];

  task automatic run_session(input vec_t v, input int idx);
    int i, cyc, k, errs, exp_n;
    logic ph, acc, fin;
    logic [7:0] ea;
    wlog.delete();
    @(posedge clk); #1;
    start = 1'b1; clear_en = v.clr; base_addr = v.base;
    @(posedge clk); #1;
    start = 1'b0; clear_en = 1'b0;

    i = 0; cyc = 0; ph = 1'b0;
    while (i < v.nwords && cyc < 600) begin
      in_valid = v.gap ? ph : 1'b1;
      in_data  = dat(idx, i);
      in_last  = (i == v.nwords - 1);
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      cyc++; ph = ~ph;
      if (acc) i++;
    end
    in_valid = 1'b0; in_last = 1'b0;
    chk($sformatf("v%0d load_words", idx), i, v.nwords);
    chk($sformatf("v%0d run_entry_cpu_rst", idx), cpu_rst, 1'b0);
    chk($sformatf("v%0d run_entry_busy", idx), busy, 1'b1);

    k = 1; fin = 1'b0;
    while (!fin && k <= 200) begin
      cpu_halt = (k == v.halt_cyc);
      start    = (k == v.start_in_run);
      @(posedge clk); #1;
      cpu_halt = 1'b0; start = 1'b0;
      if (k == v.start_in_run) chk($sformatf("v%0d start_ignored_in_run", idx), cpu_rst, 1'b0);
      fin = done;
      k++;
    end
    chk($sformatf("v%0d run_ends", idx), fin, 1'b1);
    chk($sformatf("v%0d done", idx), done, v.exp_done);
    chk($sformatf("v%0d timeout", idx), timeout, v.exp_to);
    chk($sformatf("v%0d run_cycles", idx), run_cycles, v.exp_run);
    chk($sformatf("v%0d cpu_rst_after", idx), cpu_rst, 1'b1);
    chk($sformatf("v%0d busy_after", idx), busy, 1'b0);
    chk($sformatf("v%0d in_ready_after", idx), in_ready, 1'b0);

    exp_n = (v.clr ? 256 : 0) + v.nwords;
    chk($sformatf("v%0d write_count", idx), wlog.size(), exp_n);
    errs = 0;
    if (v.clr) begin
      for (int j = 0; j < 256; j++)
        if (j >= wlog.size() || wlog[j] !== {8'(j), 8'h00}) errs++;
      chk($sformatf("v%0d clear_writes", idx), errs, 0);
    end
    errs = 0;
    for (int w = 0; w < v.nwords; w++) begin
      int p;
      p  = (v.clr ? 256 : 0) + w;
      ea = v.base + 8'(w);
      if (p >= wlog.size() || wlog[p] !== {ea, dat(idx, w)}) errs++;
    end
    chk($sformatf("v%0d load_writes", idx), errs, 0);
    if (wlog.size() > 0) chk($sformatf("v%0d last_addr", idx), wlog[wlog.size()-1][15:8], v.exp_last);

    repeat (3) @(posedge clk);
    #1;
    chk($sformatf("v%0d run_cycles_frozen", idx), run_cycles, v.exp_run);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int steps;
    logic found;
    logic [7:0] m38;
    vec_t vb;

    vecs[0] = '{clr:1'b1, base:8'd0,   nwords:15, gap:1'b0, halt_cyc:40,  start_in_run:0, exp_done:1'b1, exp_to:1'b0, exp_run:40,  exp_last:8'd14};
    vecs[1] = '{clr:1'b0, base:8'd16,  nwords:5,  gap:1'b1, halt_cyc:0,   start_in_run:0, exp_done:1'b1, exp_to:1'b1, exp_run:100, exp_last:8'd20};
    vecs[2] = '{clr:1'b0, base:8'd255, nwords:3,  gap:1'b0, halt_cyc:100, start_in_run:0, exp_done:1'b1, exp_to:1'b0, exp_run:100, exp_last:8'd1};
    vecs[3] = '{clr:1'b0, base:8'd200, nwords:1,  gap:1'b0, halt_cyc:1,   start_in_run:0, exp_done:1'b1, exp_to:1'b0, exp_run:1,   exp_last:8'd200};
    vecs[4] = '{clr:1'b1, base:8'd128, nwords:4,  gap:1'b1, halt_cyc:99,  start_in_run:0, exp_done:1'b1, exp_to:1'b0, exp_run:99,  exp_last:8'd131};
    vecs[5] = '{clr:1'b0, base:8'd10,  nwords:1,  gap:1'b0, halt_cyc:6,   start_in_run:3, exp_done:1'b1, exp_to:1'b0, exp_run:6,   exp_last:8'd10};

    // Reset values, with in_valid asserted to show it is ignored.
    in_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst in_ready", in_ready, 1'b0);
    chk("rst mem_wr", mem_wr, 1'b0);
    chk("rst mem_addr", mem_addr, 8'h00);
    chk("rst mem_wdata", mem_wdata, 8'h00);
    chk("rst cpu_rst", cpu_rst, 1'b1);
    chk("rst busy", busy, 1'b0);
    chk("rst done", done, 1'b0);
    chk("rst timeout", timeout, 1'b0);
    chk("rst run_cycles", run_cycles, 16'h0000);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("idle in_ready", in_ready, 1'b0);
    chk("idle mem_wr", mem_wr, 1'b0);
    chk("idle busy", busy, 1'b0);
    in_valid = 1'b0;

    for (int n = 0; n < 6; n++) run_session(vecs[n], n);

    // Reset in the middle of a clear: memory keeps what was written.
    vb = '{clr:1'b0, base:8'd30, nwords:16, gap:1'b0, halt_cyc:5, start_in_run:0,
           exp_done:1'b1, exp_to:1'b0, exp_run:5, exp_last:8'd45};
    run_session(vb, 9);
    m38 = mem_model[38];
    wlog.delete();
    @(posedge clk); #1;
    start = 1'b1; clear_en = 1'b1; base_addr = 8'd0;
    @(posedge clk); #1;
    start = 1'b0; clear_en = 1'b0;
    found = 1'b0; steps = 0;
    while (!found && steps < 300) begin
      if (mem_wr && mem_addr == 8'd37) found = 1'b1;
      else begin
        @(posedge clk); #1;
        steps++;
      end
    end
    chk("midclear reach_addr37", found, 1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midclear mem_wr", mem_wr, 1'b0);
    chk("midclear cpu_rst", cpu_rst, 1'b1);
    chk("midclear busy", busy, 1'b0);
    chk("midclear in_ready", in_ready, 1'b0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("midclear idle_busy", busy, 1'b0);
    chk("midclear write_count", wlog.size(), 38);
    chk("midclear mem37", mem_model[37], 8'h00);
    chk("midclear mem38_kept", mem_model[38], m38);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
